// File: rtl/interp_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : interp_window_streamer
// Captures an integer pixel window and streams its rows, then its columns, then
// (with macro INTERP_HALF_PEL_EN) the A/B/C half-pel rows over a valid/ready port.
// Revision : 1.0
// ============================================================================
module interp_window_streamer #(
  parameter  int NUM_PIXEL = 8,
  parameter  int TAPS      = 8,
  parameter  int PIXEL_W   = 8,
  parameter  int TAG_W     = 8,
  localparam int W         = NUM_PIXEL + TAPS - 1,
  localparam int ROW_W     = W * PIXEL_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TAG_W-1:0]             start_tag,
  input  logic [W*ROW_W-1:0]           integer_array,
  input  logic [NUM_PIXEL*ROW_W-1:0]   a_half_array,
  input  logic [NUM_PIXEL*ROW_W-1:0]   b_half_array,
  input  logic [NUM_PIXEL*ROW_W-1:0]   c_half_array,
  output logic                         busy,
  output logic [ROW_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0]                   out_phase,
  output logic [7:0]                   out_index,
  output logic                         out_last,
  output logic [TAG_W-1:0]             out_tag
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INT_ROW = 3'd1,
    S_INT_COL = 3'd2,
    S_HALF_A  = 3'd3,
    S_HALF_B  = 3'd4,
    S_HALF_C  = 3'd5
  } phase_t;

  localparam logic [7:0] C_W_LAST  = 8'(W - 1);
  localparam logic [7:0] C_NP_LAST = 8'(NUM_PIXEL - 1);
`ifdef INTERP_HALF_PEL_EN
  localparam phase_t     C_FINAL_PHASE = S_HALF_C;
  localparam logic [7:0] C_FINAL_LAST  = C_NP_LAST;
`else
  localparam phase_t     C_FINAL_PHASE = S_INT_COL;
  localparam logic [7:0] C_FINAL_LAST  = C_W_LAST;
`endif

  phase_t             phase_q, phase_d;
  logic [7:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [ROW_W-1:0]   data_q, data_d;
  logic [W*ROW_W-1:0] int_arr_q, int_arr_d;
  logic               w_load;
  logic [7:0]         w_phase_last;
  phase_t             w_next_phase;

  // A start is only honoured while no stream is in flight.
  assign w_load    = start && !valid_q;
  assign int_arr_d = w_load ? integer_array : int_arr_q;

`ifdef INTERP_HALF_PEL_EN
  logic [NUM_PIXEL*ROW_W-1:0] a_arr_q, a_arr_d, b_arr_q, b_arr_d, c_arr_q, c_arr_d;
  assign a_arr_d = w_load ? a_half_array : a_arr_q;
  assign b_arr_d = w_load ? b_half_array : b_arr_q;
  assign c_arr_d = w_load ? c_half_array : c_arr_q;

  always_ff @(posedge clock) begin
    a_arr_q <= a_arr_d;
    b_arr_q <= b_arr_d;
    c_arr_q <= c_arr_d;
  end
`else
  logic w_unused_half;
  assign w_unused_half = ^{a_half_array, b_half_array, c_half_array};
`endif

  always_ff @(posedge clock) begin
    int_arr_q <= int_arr_d;
  end

  always_comb begin
    w_phase_last = (phase_q == S_INT_ROW || phase_q == S_INT_COL) ? C_W_LAST : C_NP_LAST;
    case (phase_q)
      S_INT_ROW: w_next_phase = S_INT_COL;
`ifdef INTERP_HALF_PEL_EN
      S_INT_COL: w_next_phase = S_HALF_A;
      S_HALF_A:  w_next_phase = S_HALF_B;
      S_HALF_B:  w_next_phase = S_HALF_C;
`endif
      default:   w_next_phase = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    if (w_load) begin
      phase_d = S_INT_ROW;
      idx_d   = 8'd0;
      valid_d = 1'b1;
      tag_d   = start_tag;
    end else if (valid_q && out_ready) begin
      if (last_q) begin
        phase_d = S_IDLE;
        idx_d   = 8'd0;
        valid_d = 1'b0;
      end else if (idx_q == w_phase_last) begin
        phase_d = w_next_phase;
        idx_d   = 8'd0;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
    last_d = valid_d && (phase_d == C_FINAL_PHASE) && (idx_d == C_FINAL_LAST);
  end

  // Next beat is built from the *_d arrays so the first beat can come straight from the inputs.
  always_comb begin
    data_d = '0;
    case (phase_d)
      S_INT_ROW: data_d = int_arr_d[int'(idx_d)*ROW_W +: ROW_W];
      S_INT_COL: begin
        for (int r = 0; r < W; r++) begin
          data_d[r*PIXEL_W +: PIXEL_W] = int_arr_d[(r*W + int'(idx_d))*PIXEL_W +: PIXEL_W];
        end
      end
`ifdef INTERP_HALF_PEL_EN
      S_HALF_A:  data_d = a_arr_d[int'(idx_d)*ROW_W +: ROW_W];
      S_HALF_B:  data_d = b_arr_d[int'(idx_d)*ROW_W +: ROW_W];
      S_HALF_C:  data_d = c_arr_d[int'(idx_d)*ROW_W +: ROW_W];
`endif
      default:   data_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= S_IDLE;
      idx_q   <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign busy      = valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_phase = phase_q;
  assign out_index = idx_q;
  assign out_last  = last_q;
  assign out_tag   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_window_streamer.sv
`default_nettype none
// Directed/random bench for interp_window_streamer; expected beats come from a
// flat beat-number model of the captured arrays.
module tb_interp_window_streamer;
  localparam int NP = 8;
  localparam int TP = 8;
  localparam int PW = 8;
  localparam int TW = 8;
  localparam int W  = NP + TP - 1;
  localparam int RW = W * PW;
`ifdef INTERP_HALF_PEL_EN
  localparam int NB = 2*W + 3*NP;
`else
  localparam int NB = 2*W;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [TW-1:0]        start_tag = '0;
  logic [W*RW-1:0]      integer_array = '0;
  logic [NP*RW-1:0]     a_half_array = '0;
  logic [NP*RW-1:0]     b_half_array = '0;
  logic [NP*RW-1:0]     c_half_array = '0;
  logic                 busy;
  logic [RW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [2:0]           out_phase;
  logic [7:0]           out_index;
  logic                 out_last;
  logic [TW-1:0]        out_tag;

  int total = 0;
  int bad   = 0;

  logic [W*RW-1:0]  m_int;
  logic [NP*RW-1:0] m_a, m_b, m_c;
  logic [TW-1:0]    m_tag;

  always #5 clock = ~clock;

  interp_window_streamer #(.NUM_PIXEL(NP), .TAPS(TP), .PIXEL_W(PW), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .start(start), .start_tag(start_tag),
    .integer_array(integer_array), .a_half_array(a_half_array),
    .b_half_array(b_half_array), .c_half_array(c_half_array),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_phase(out_phase), .out_index(out_index), .out_last(out_last), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic rand_arrays();
    for (int i = 0; i < W*W; i++) integer_array[i*PW +: PW] = 8'($urandom);
    for (int i = 0; i < NP*W; i++) begin
      a_half_array[i*PW +: PW] = 8'($urandom);
      b_half_array[i*PW +: PW] = 8'($urandom);
      c_half_array[i*PW +: PW] = 8'($urandom);
    end
  endtask

  // Beat k of the stream: W rows, W columns, then NP rows of each half-pel array.
  function automatic void exp_beat(input int k, output logic [2:0] ph, output logic [7:0] ix,
                                   output logic [RW-1:0] d, output logic lst);
    int h;
    int j;
    d = '0;
    if (k < W) begin
      ph = 3'd1; ix = 8'(k); d = m_int[k*RW +: RW];
    end else if (k < 2*W) begin
      ph = 3'd2; ix = 8'(k - W);
      for (int r = 0; r < W; r++) d[r*PW +: PW] = m_int[(r*W + (k - W))*PW +: PW];
    end else begin
      h = (k - 2*W) / NP;
      j = (k - 2*W) % NP;
      ph = 3'(3 + h); ix = 8'(j);
      d = (h == 0) ? m_a[j*RW +: RW] : (h == 1) ? m_b[j*RW +: RW] : m_c[j*RW +: RW];
    end
    lst = (k == NB - 1);
  endfunction

  task automatic check_idle(input string pfx);
    check({pfx, "_valid"}, out_valid, '0);
    check({pfx, "_busy"},  busy,      '0);
    check({pfx, "_phase"}, out_phase, '0);
    check({pfx, "_index"}, out_index, '0);
    check({pfx, "_data"},  out_data,  '0);
    check({pfx, "_last"},  out_last,  '0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the last handshake.
  // mode 0: ready high, 1: random ready. stall_k/inject_k < 0 disable those events.
  task automatic run_stream(input logic [TW-1:0] tag, input int mode, input int stall_k,
                            input int inject_k, input bit pattern);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    bit injected = 0;
    bit rdy;
    logic [2:0] ph;
    logic [7:0] ix;
    logic [RW-1:0] d;
    logic lst;
    start = 1'b1; start_tag = tag;
    m_int = integer_array; m_a = a_half_array; m_b = b_half_array; m_c = c_half_array; m_tag = tag;
    @(negedge clock);
    start = 1'b0;
    rand_arrays();
    start_tag = ~tag;
    while (k < NB && cyc < 2000) begin
      exp_beat(k, ph, ix, d, lst);
      check("valid", out_valid, 1'b1);
      check("busy",  busy,      1'b1);
      check("phase", out_phase, ph);
      check("index", out_index, ix);
      check("data",  out_data,  d);
      check("last",  out_last,  lst);
      check("tag",   out_tag,   m_tag);
      if (pattern && k == W + 3)
        for (int r = 0; r < W; r++) check("col3_byte", out_data[r*PW +: PW], RW'(16*r + 3));
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (k == stall_k && stalls < 5) begin rdy = 1'b0; stalls++; end
      start = (k == inject_k && !injected);
      if (k == inject_k) injected = 1;
      out_ready = rdy;
      @(negedge clock);
      cyc++;
      if (rdy) k++;
    end
    start = 1'b0;
    check("stream_beats", RW'(k), RW'(NB));
    if (mode == 0 && stall_k < 0) check("stream_cycles", RW'(cyc), RW'(NB));
    if (stall_k >= 0) check("stall_cycles", RW'(stalls), RW'(5));
    check_idle("end");
  endtask

  initial begin
    rand_arrays();
    repeat (2) @(negedge clock);
    check_idle("rst");
    check("rst_tag", out_tag, '0);
    reset = 1'b0;
    @(negedge clock);

    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) integer_array[(r*W + c)*PW +: PW] = 8'(16*r + c);
    run_stream(8'hA1, 0, -1, -1, 1'b1);
    run_stream(8'h3C, 0, 7, -1, 1'b0);
    run_stream(8'h77, 1, -1, (NB > 2*W) ? 2*W + 2 : W + 2, 1'b0);

    start = 1'b1; start_tag = 8'h5A;
    @(negedge clock);
    start = 1'b0; out_ready = 1'b1;
    repeat (W + 4) @(negedge clock);
    check("pre_rst_phase", out_phase, 3'd2);
    #2 reset = 1'b1;
    #1 check_idle("arst");
    check("arst_tag", out_tag, '0);
    #4 reset = 1'b0;
    @(negedge clock);
    check_idle("post_rst");
    run_stream(8'hC3, 1, -1, -1, 1'b0);
    run_stream(8'h11, 0, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/interp_window_streamer.md
INTERP_WINDOW_STREAMER -- requirements
Module: interp_window_streamer

Interface
REQ-001 SHALL have parameter NUM_PIXEL, default 8, meaning output block edge in pixels.
REQ-002 SHALL have parameter TAPS, default 8, meaning filter taps; window edge W = NUM_PIXEL+TAPS-1 (15 by default).
REQ-003 SHALL have parameter PIXEL_W, default 8, meaning bits per pixel.
REQ-004 SHALL have parameter TAG_W, default 8, meaning width of the sideband tag.
REQ-005 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to capture arrays and begin streaming.
- start_tag  in  TAG_W  tag captured with start.
- integer_array  in  W*W*PIXEL_W  integer window; row r at [r*W*PIXEL_W +: W*PIXEL_W].
- a_half_array, b_half_array, c_half_array  in  NUM_PIXEL*W*PIXEL_W each  half-pel rows; row k at [k*W*PIXEL_W +: W*PIXEL_W].
- busy  out  1  high from accepted start until the last beat handshakes.
- out_data  out  W*PIXEL_W  streamed vector.
- out_valid  out  1  out_data qualified.
- out_ready  in  1  downstream accept.
- out_phase  out  3  0=IDLE,1=INT_ROW,2=INT_COL,3=HALF_A,4=HALF_B,5=HALF_C.
- out_index  out  8  beat index within phase.
- out_last  out  1  final beat of the stream.
- out_tag  out  TAG_W  captured start_tag.

Function
REQ-006 A beat SHALL transfer when out_valid and out_ready are both high on a rising clock edge.
REQ-007 start with busy low SHALL capture all four arrays and start_tag into internal registers; later input changes SHALL NOT affect the stream.
REQ-008 start with busy high SHALL be ignored with no state change.
REQ-009 The first beat SHALL appear registered, out_valid high, one cycle after start is accepted.
REQ-010 Phase INT_ROW SHALL emit W beats; beat i = captured integer row i.
REQ-011 Phase INT_COL SHALL emit W beats; beat c carries pixel c of integer row r at out_data[r*PIXEL_W +: PIXEL_W] for r = 0..W-1.
REQ-012 Phases HALF_A, HALF_B, HALF_C SHALL each emit NUM_PIXEL beats; beat k = captured row k of that array.
REQ-013 out_index SHALL restart at 0 on each phase entry and increment by 1 per handshake.
REQ-014 While out_valid is high and out_ready low, out_data, out_phase, out_index, out_last and out_tag SHALL hold stable.
REQ-015 out_valid SHALL remain high between beats with no bubble while out_ready is high (one beat per cycle).
REQ-016 out_last SHALL be high only on the final beat (HALF_C index NUM_PIXEL-1 with HALF_PEL_EN defined).
REQ-017 After the last handshake, out_valid and busy SHALL be low and out_phase 0 in the following cycle; a new start is accepted from then on.
REQ-018 When out_valid is low, out_data SHALL be zero.

Reset
REQ-019 reset high SHALL asynchronously force out_valid=0, busy=0, out_last=0, out_phase=0, out_index=0, out_data=0, out_tag=0, and the sequencer to IDLE, aborting any stream mid-operation.
REQ-020 Captured array registers need not be reset.

Configuration
REQ-021 Macro INTERP_HALF_PEL_EN defined: the stream covers INT_ROW, INT_COL, HALF_A, HALF_B, HALF_C (2W+3*NUM_PIXEL beats, 54 by default).
REQ-022 Macro INTERP_HALF_PEL_EN undefined: half-pel ports remain present but unused, no half-pel capture registers are built, the stream ends after INT_COL (2W beats, 30 by default), and out_last is set on INT_COL index W-1.

Verification
REQ-023 Defaults, macro defined, integer pixel (r,c)=16*r+c, out_ready tied high, start at cycle 0 -> 54 consecutive beats from cycle 1; INT_COL beat 3 byte r = 16*r+3; out_last at beat 54.
REQ-024 out_ready low for 5 cycles at INT_ROW index 7 -> outputs held identical for all 5 cycles; row 7 transfers exactly once.
REQ-025 Second start during HALF_A with a different tag -> ignored; out_tag keeps the first tag; stream completes normally.
REQ-026 reset asserted mid-INT_COL, not aligned to clock -> outputs zero immediately; start after release -> stream restarts at INT_ROW index 0.
REQ-027 Macro undefined -> 30 beats; out_last on INT_COL index 14; out_phase never exceeds 2.
REQ-028 Start issued the cycle after the last handshake -> accepted; new stream begins with no lost beats.
